mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port (req/addr_ok/data_ok) between the CPU instruction-fetch and data-access ports.
//  Sits between the CPU core and the memory bridge. Fixed data-over-inst priority with a starvation guard.
//  One transaction outstanding at a time; captures the winning request and routes the response to its owner.
// PARAMETERS
//  STARVE_LIMIT  8   consecutive IDLE cycles with inst_req=1 and data winning before inst is forced to win (>=1)
//  ADDR_W        32  address width
//  DATA_W        32  data width
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  reset          in   1       synchronous, active-high
//  inst_req       in   1       inst-side request valid
//  inst_wr        in   1       inst-side write (normally 0)
//  inst_size      in   2       0=byte,1=half,2=word
//  inst_addr      in   ADDR_W  inst-side address
//  inst_wstrb     in   4       inst-side byte strobes
//  inst_wdata     in   DATA_W  inst-side write data
//  inst_addr_ok   out  1       inst request accepted this cycle
//  inst_data_ok   out  1       inst response valid (1 cycle)
//  inst_rdata     out  DATA_W  inst read data
//  data_*         --   --      same set as inst_* for the data side
//  mem_req        out  1       request to memory
//  mem_wr/size/addr/wstrb/wdata  out  1/2/ADDR_W/4/DATA_W  latched request fields
//  mem_addr_ok    in   1       memory accepted the request
//  mem_data_ok    in   1       memory response (read data or write ack)
//  mem_rdata      in   DATA_W  memory read data
// BEHAVIOUR
//  States: IDLE -> REQ -> RESP -> IDLE. Owner register: NONE/INST/DATA.
//  IDLE: if data_req and not starved -> data wins; else if inst_req -> inst wins. Winner's *_addr_ok=1
//   combinationally this cycle; wr/size/addr/wstrb/wdata latched; owner set; next state REQ. Loser's addr_ok=0.
//  REQ: mem_req=1 with latched fields, held stable until mem_addr_ok=1 -> RESP. No requester addr_ok in REQ/RESP.
//  RESP: mem_req=0; on mem_data_ok=1 assert owner's *_data_ok=1 for that cycle, *_rdata=mem_rdata; -> IDLE.
//   Writes also complete on mem_data_ok.
//  Min latency: addr_ok cycle N, mem_req N+1, data_ok N+2 when memory answers zero-wait. New accept earliest N+3.
//  Starvation counter: clog2(STARVE_LIMIT+1) bits; +1 per IDLE cycle with inst_req=1 and data granted;
//   saturates at STARVE_LIMIT; cleared when inst is granted. counter==STARVE_LIMIT and inst_req=1 -> inst wins
//   even with data_req=1.
//  Both req in IDLE, counter<STARVE_LIMIT -> data. mem_data_ok in IDLE or REQ is ignored (dropped).
//  Non-owner *_rdata is don't-care; non-owner *_data_ok is always 0.
//  Reset (any state, incl. mid-transaction): state=IDLE, owner=NONE, counter=0, mem_req=0, all addr_ok/data_ok=0,
//   latched fields=0. An in-flight transaction is abandoned; the memory side is reset together.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: extra outputs perf_inst_cnt[31:0], perf_data_cnt[31:0], perf_wait_cnt[31:0]:
//   grants to inst, grants to data, cycles in REQ with mem_addr_ok=0; wrap at 2^32; cleared by reset.
//  Not defined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE/REQ/RESP), owner encoding (NONE/INST/DATA), size codes.
//  Sub-module mem_arb_perf_cnt (three counters), instantiated only under MEM_ARB_PERF_EN.
// TESTING
//  1 inst_req only, addr=0x1c000000, memory zero-wait rdata=0x02800c0c -> inst_addr_ok N, mem_req N+1,
//    inst_data_ok N+2 with 0x02800c0c, data_data_ok stays 0.
//  2 inst_req+data_req same cycle, data rd 0x00001000 -> data wins; mem_addr=0x00001000; inst granted after data_ok.
//  3 data_req held high with inst_req, STARVE_LIMIT=8 -> after 8 data grants inst wins the next IDLE; counter cleared.
//  4 data write addr=0x8, wstrb=0x3, wdata=0xbeef, mem_addr_ok delayed 3 cycles -> mem_req+fields stable 4 cycles;
//    data_data_ok on mem_data_ok.
//  5 reset asserted in RESP -> next cycle IDLE, all ok outputs 0; late mem_data_ok ignored; next request served normally.
//  6 MEM_ARB_PERF_EN: test 2 then 3 -> perf_data_cnt/perf_inst_cnt match grant counts; perf_wait_cnt=3 after test 4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared encodings for the instruction/data memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_t;

    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arb_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_perf_cnt
// Purpose  : Free-running grant and wait-cycle counters (wrap at 2^32).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inst_grant,
    input  logic        i_data_grant,
    input  logic        i_wait_cycle,
    output logic [31:0] o_inst_cnt,
    output logic [31:0] o_data_cnt,
    output logic [31:0] o_wait_cnt
);

    logic [31:0] r_inst_cnt;
    logic [31:0] r_data_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_cnt <= '0;
            r_data_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (i_inst_grant) r_inst_cnt <= r_inst_cnt + 32'd1;
            if (i_data_grant) r_data_cnt <= r_data_cnt + 32'd1;
            if (i_wait_cycle) r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign o_inst_cnt = r_inst_cnt;
    assign o_data_cnt = r_data_cnt;
    assign o_wait_cnt = r_wait_cnt;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one SRAM-like port between inst and data requesters;
//            data has priority, inst is forced through after STARVE_LIMIT
//            lost cycles. MEM_ARB_PERF_EN adds grant/wait counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [3:0]        inst_wstrb,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_inst_cnt,
    output logic [31:0]       perf_data_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    localparam int              CW           = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   c_starve_max = CW'(STARVE_LIMIT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic [CW-1:0]     r_starve;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_wdata;

    logic              w_starved;
    logic              w_grant_data;
    logic              w_grant_inst;
    logic              w_resp_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_data = 1'b0;
        w_grant_inst = 1'b0;
        w_starved    = inst_req && (r_starve == c_starve_max);
        w_resp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_data = data_req && !w_starved;
                w_grant_inst = inst_req && !w_grant_data;
                if (w_grant_data || w_grant_inst) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (mem_addr_ok) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // mem_data_ok outside RESP never reaches a requester
                w_resp_done = mem_data_ok;
                if (mem_data_ok) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_NONE;
            r_starve <= '0;
            r_wr     <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_data) begin
                r_owner <= OWN_DATA;
                r_wr    <= data_wr;
                r_size  <= data_size;
                r_addr  <= data_addr;
                r_wstrb <= data_wstrb;
                r_wdata <= data_wdata;
            end else if (w_grant_inst) begin
                r_owner <= OWN_INST;
                r_wr    <= inst_wr;
                r_size  <= inst_size;
                r_addr  <= inst_addr;
                r_wstrb <= inst_wstrb;
                r_wdata <= inst_wdata;
            end else if (w_resp_done) begin
                r_owner <= OWN_NONE;
            end
            // Count only cycles where inst actually waited behind a data grant
            if (w_grant_inst) begin
                r_starve <= '0;
            end else if (w_grant_data && inst_req && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = w_resp_done && (r_owner == OWN_INST);
    assign data_data_ok = w_resp_done && (r_owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req      = (r_state == ST_REQ);
    assign mem_wr       = r_wr;
    assign mem_size     = r_size;
    assign mem_addr     = r_addr;
    assign mem_wstrb    = r_wstrb;
    assign mem_wdata    = r_wdata;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst          (reset),
        .i_inst_grant (w_grant_inst),
        .i_data_grant (w_grant_data),
        .i_wait_cycle (mem_req && !mem_addr_ok),
        .o_inst_cnt   (perf_inst_cnt),
        .o_data_cnt   (perf_data_cnt),
        .o_wait_cnt   (perf_wait_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized scoreboard bench for mem_port_arbiter with a
//            behavioural memory; perf counters checked under MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = '0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic [3:0]  inst_wstrb = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [3:0]  data_wstrb = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_inst_cnt, perf_data_cnt, perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;

    req_t  mem_q[$];
    resp_t resp_q[$];
    resp_t mon_r;

    int checks = 0, errors = 0;
    int cyc = 0, grant_cyc = -100, starve = 0;
    int exp_inst_grants = 0, exp_data_grants = 0, exp_wait = 0;
    bit model_busy = 1'b0, inst_got = 1'b0, data_got = 1'b0, mem_hold = 1'b0;
    int mem_phase = 0, mem_dly = 0;
    logic [31:0] mem_lat_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h02800c0c;
    endfunction

    function automatic req_t rand_req(input int wr_pct);
        req_t r;
        r.wr    = ($urandom_range(0, 99) < wr_pct);
        r.size  = 2'($urandom_range(0, 2));
        r.addr  = $urandom;
        r.wstrb = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
    endtask

    // Behavioural memory: random accept and response delays, stray data_ok pulses
    // whenever no response is owed.
    always @(negedge clk) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom;
        if (mem_phase == 2) begin
            if (!mem_hold) begin
                if (mem_dly == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = mem_fn(mem_lat_addr);
                    mem_phase   = 0;
                end else begin
                    mem_dly--;
                end
            end
        end else if (mem_req === 1'b1) begin
            if (mem_phase == 0) begin
                mem_dly   = $urandom_range(0, 3);
                mem_phase = 1;
            end
            if (mem_dly == 0) begin
                mem_addr_ok  = 1'b1;
                mem_lat_addr = mem_addr;
                mem_dly      = $urandom_range(0, 3);
                mem_phase    = 2;
            end else begin
                mem_dly--;
                mem_data_ok = ($urandom_range(0, 3) == 0);
            end
        end else begin
            mem_data_ok = ($urandom_range(0, 7) == 0);
        end
    end

    // Monitor: compares memory-side requests and requester responses against the queues.
    always @(negedge clk) begin
        #2;
        if (cyc == grant_cyc + 1) check("mem_req_latency", mem_req, 1'b1);
        if (mem_req === 1'b1) begin
            if (mem_q.size() == 0) begin
                fail_evt("mem_req_unexpected");
            end else begin
                check("mem_fields", {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, mem_q[0]);
                if (mem_addr_ok) void'(mem_q.pop_front());
                else exp_wait++;
            end
        end
        if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
            if (resp_q.size() == 0) begin
                fail_evt("data_ok_unexpected");
            end else begin
                mon_r = resp_q.pop_front();
                check("data_ok_owner", {inst_data_ok, data_data_ok}, mon_r.is_data ? 2'b01 : 2'b10);
                check("rdata", mon_r.is_data ? data_rdata : inst_rdata, mon_r.rdata);
                model_busy = 1'b0;
            end
        end
    end

    // One cycle of stimulus plus the reference arbitration decision.
    task automatic step(input int p_i, input int p_d);
        bit exp_i, exp_d;
        req_t r;
        @(negedge clk);
        if (inst_got) inst_req = 1'b0;
        if (data_got) data_req = 1'b0;
        if (!inst_req && $urandom_range(0, 99) < p_i) begin
            r = rand_req(10);
            {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata} = r;
            inst_req = 1'b1;
        end
        if (!data_req && $urandom_range(0, 99) < p_d) begin
            r = rand_req(50);
            {data_wr, data_size, data_addr, data_wstrb, data_wdata} = r;
            data_req = 1'b1;
        end
        #1;
        exp_d = !model_busy && data_req && !(inst_req && starve == STARVE_LIMIT);
        exp_i = !model_busy && inst_req && !exp_d;
        check("inst_addr_ok", inst_addr_ok, exp_i);
        check("data_addr_ok", data_addr_ok, exp_d);
        inst_got = exp_i;
        data_got = exp_d;
        if (exp_d) begin
            mem_q.push_back({data_wr, data_size, data_addr, data_wstrb, data_wdata});
            resp_q.push_back({1'b1, mem_fn(data_addr)});
            if (inst_req && starve < STARVE_LIMIT) starve++;
            exp_data_grants++;
        end else if (exp_i) begin
            mem_q.push_back({inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata});
            resp_q.push_back({1'b0, mem_fn(inst_addr)});
            starve = 0;
            exp_inst_grants++;
        end
        if (exp_i || exp_d) begin
            model_busy = 1'b1;
            grant_cyc  = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((model_busy || inst_req || data_req) && n < 200) begin
            step(0, 0);
            n++;
        end
        if (n >= 200) fail_evt("drain_timeout");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_mem_fields"}, {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, 71'd0);
        check({tag, "_data_ok"}, {inst_data_ok, data_data_ok}, 2'b00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check_idle_outputs("reset");

        for (int i = 0; i < 800; i++) step(30, 30);
        for (int i = 0; i < 600; i++) step(100, 100);
        for (int i = 0; i < 400; i++) step(70, 20);
        drain();

        // Abandon a transaction while the memory is still owing its response.
        mem_hold = 1'b1;
        step(0, 100);
        for (int i = 0; i < 10 && mem_phase != 2; i++) step(0, 0);
        if (mem_phase != 2) fail_evt("reach_resp_timeout");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_q.delete();
        resp_q.delete();
        model_busy = 1'b0;
        starve = 0;
        grant_cyc = -100;
        inst_got = 1'b0;
        data_got = 1'b0;
        exp_inst_grants = 0;
        exp_data_grants = 0;
        exp_wait = 0;
        mem_hold = 1'b0;
        #2;
        check_idle_outputs("mid_reset");
        repeat (6) step(0, 0);
        for (int i = 0; i < 300; i++) step(50, 50);
        drain();
        repeat (3) step(0, 0);
        check("queues_empty", resp_q.size() + mem_q.size(), 0);
`ifdef MEM_ARB_PERF_EN
        check("perf_inst_cnt", perf_inst_cnt, exp_inst_grants);
        check("perf_data_cnt", perf_data_cnt, exp_data_grants);
        check("perf_wait_cnt", perf_wait_cnt, exp_wait);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
